// File: rtl/grid_traffic_pkg.sv
// Shared types, field layouts and head-flit packing for grid traffic generation.
package grid_traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_e;

  // Packet length minus one and body flit index widths (1..4 flits).
  localparam int unsigned LENM1_W = 2;
  localparam int unsigned IDX_W   = 2;

  // Random vector slicing: draw in the low byte, destination and length above it.
  localparam int unsigned RV_DRAW_LSB = 0;
  localparam int unsigned RV_DRAW_W   = 8;
  localparam int unsigned RV_DX_LSB   = RV_DRAW_LSB + RV_DRAW_W;

  // Widest flit the packing helper produces; callers truncate to their DATA_WIDTH.
  localparam int unsigned FLIT_MAX_W = 64;

  // Head flit layout, LSB first: seq, lenm1, dest_y, dest_x, zero pad.
  localparam int unsigned HEAD_SEQ_LSB = 0;

  function automatic int unsigned head_lenm1_lsb(input int unsigned seq_w);
    return HEAD_SEQ_LSB + seq_w;
  endfunction

  function automatic int unsigned head_dy_lsb(input int unsigned seq_w);
    return head_lenm1_lsb(seq_w) + LENM1_W;
  endfunction

  function automatic int unsigned head_dx_lsb(input int unsigned seq_w,
                                              input int unsigned y_bits);
    return head_dy_lsb(seq_w) + y_bits;
  endfunction

  // Low-w-bit mask, saturating at the full helper width.
  function automatic logic [FLIT_MAX_W-1:0] field_mask(input int unsigned w);
    if (w >= FLIT_MAX_W) return '1;
    return (FLIT_MAX_W'(1) << w) - FLIT_MAX_W'(1);
  endfunction

  // Pack a head flit; shared by the generator, router decode and scoreboards.
  function automatic logic [FLIT_MAX_W-1:0] make_head_flit(
    input int unsigned x_bits,
    input int unsigned y_bits,
    input int unsigned seq_w,
    input logic [31:0] dest_x,
    input logic [31:0] dest_y,
    input logic [31:0] lenm1,
    input logic [31:0] seq
  );
    logic [FLIT_MAX_W-1:0] f;
    f = (FLIT_MAX_W'(seq) & field_mask(seq_w)) << HEAD_SEQ_LSB;
    f |= (FLIT_MAX_W'(lenm1) & field_mask(LENM1_W)) << head_lenm1_lsb(seq_w);
    f |= (FLIT_MAX_W'(dest_y) & field_mask(y_bits)) << head_dy_lsb(seq_w);
    f |= (FLIT_MAX_W'(dest_x) & field_mask(x_bits)) << head_dx_lsb(seq_w, y_bits);
    return f;
  endfunction

endpackage

// File: rtl/rand_traffic_gen.sv
// Random packet source feeding a grid router injection port over valid/ready.
module rand_traffic_gen
  import grid_traffic_pkg::*;
#(
  parameter int unsigned RAND_WIDTH = 64,
  parameter int unsigned X_BITS     = 2,
  parameter int unsigned Y_BITS     = 2,
  parameter int unsigned MY_X       = 0,
  parameter int unsigned MY_Y       = 0,
  parameter int unsigned SEQ_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            inject_rate,
  input  logic [RAND_WIDTH-1:0] rand_vect,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  flit_head,
  output logic                  flit_tail,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic [15:0]           pkt_count,
  output logic                  busy
);

  localparam int unsigned RV_DY_LSB  = RV_DX_LSB + X_BITS;
  localparam int unsigned RV_LEN_LSB = RV_DY_LSB + Y_BITS;
  localparam int unsigned CNT_W      = 16;

  state_e                state_q, state_d;
  logic [X_BITS-1:0]     dest_x_q, dest_x_d;
  logic [Y_BITS-1:0]     dest_y_q, dest_y_d;
  logic [LENM1_W-1:0]    lenm1_q, lenm1_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic                  valid_q, valid_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;

  logic [RV_DRAW_W-1:0]  draw_c;
  logic [X_BITS-1:0]     dx_c, dest_x_new_c;
  logic [Y_BITS-1:0]     dy_c;
  logic [LENM1_W-1:0]    lenm1_rv_c;
  logic [IDX_W-1:0]      idx_inc_c;
  logic                  start_c;
  logic                  accept_c;
  logic                  rand_unused_c;

  // Random fields; only consulted while idle.
  assign draw_c     = rand_vect[RV_DRAW_LSB +: RV_DRAW_W];
  assign dx_c       = rand_vect[RV_DX_LSB +: X_BITS];
  assign dy_c       = rand_vect[RV_DY_LSB +: Y_BITS];
  assign lenm1_rv_c = rand_vect[RV_LEN_LSB +: LENM1_W];
  assign rand_unused_c = ^rand_vect;

  // Never address ourselves: flip the X LSB when the draw lands on this node.
  assign dest_x_new_c = ((dx_c == X_BITS'(MY_X)) && (dy_c == Y_BITS'(MY_Y)))
                      ? (dx_c ^ X_BITS'(1)) : dx_c;

  assign start_c   = enable && (draw_c < inject_rate);
  assign accept_c  = valid_q && flit_ready;
  assign idx_inc_c = idx_q + IDX_W'(1);

  // Next-state and next-output logic; outputs hold unless a transition fires.
  always_comb begin
    state_d   = state_q;
    dest_x_d  = dest_x_q;
    dest_y_d  = dest_y_q;
    lenm1_d   = lenm1_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    pkt_cnt_d = pkt_cnt_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d  = HEAD;
          dest_x_d = dest_x_new_c;
          dest_y_d = dy_c;
          lenm1_d  = lenm1_rv_c;
          idx_d    = '0;
          valid_d  = 1'b1;
          head_d   = 1'b1;
          tail_d   = (lenm1_rv_c == '0);
          data_d   = DATA_WIDTH'(make_head_flit(X_BITS, Y_BITS, SEQ_WIDTH,
                                                32'(dest_x_new_c), 32'(dy_c),
                                                32'(lenm1_rv_c), 32'(seq_q)));
        end
      end
      HEAD, BODY: begin
        if (accept_c) begin
          if (tail_q) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            head_d    = 1'b0;
            tail_d    = 1'b0;
            data_d    = '0;
            seq_d     = seq_q + SEQ_WIDTH'(1);
            pkt_cnt_d = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
          end else begin
            state_d = BODY;
            idx_d   = idx_inc_c;
            head_d  = 1'b0;
            tail_d  = (idx_inc_c == lenm1_q);
            data_d  = DATA_WIDTH'({seq_q, idx_inc_c});
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        head_d  = 1'b0;
        tail_d  = 1'b0;
        data_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dest_x_q  <= '0;
      dest_y_q  <= '0;
      lenm1_q   <= '0;
      idx_q     <= '0;
      seq_q     <= '0;
      pkt_cnt_q <= '0;
      valid_q   <= 1'b0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_x_q  <= dest_x_d;
      dest_y_q  <= dest_y_d;
      lenm1_q   <= lenm1_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      pkt_cnt_q <= pkt_cnt_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  assign flit_valid = valid_q;
  assign flit_head  = head_q;
  assign flit_tail  = tail_q;
  assign flit_data  = data_q;
  assign pkt_count  = pkt_cnt_q;
  assign busy       = busy_q;

endmodule
